// File: rtl/test_run_controller.sv
// test_run_controller: end-of-test controller for simulation / prototype harnesses.
// Sequences the DUT reset, tracks N_CH masked success/failure channels, applies a
// cycle timeout and a heartbeat stall watchdog, and latches one pass/fail verdict.
// Optional: define TEST_RUN_TRACE_EN to print state transitions
// (simulation only; also excluded when SYNTHESIS is defined).
module test_run_controller #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned STALL_W      = 16,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned DRAIN_CYCLES = 8,
  localparam int unsigned FC_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CNT_W-1:0]   cfg_max_cycles,
  input  logic [STALL_W-1:0] cfg_stall_limit,
  input  logic [N_CH-1:0]    cfg_ch_mask,
  input  logic [N_CH-1:0]    ch_success,
  input  logic [N_CH-1:0]    ch_failure,
  input  logic               heartbeat,
  output logic               dut_reset,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [N_CH-1:0]    ch_done,
  output logic               done,
  output logic               passed,
  output logic [1:0]         fail_code,
  output logic [FC_W-1:0]    fail_channel
);

  localparam int unsigned HC_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned DC_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {HOLD, RUN, DRAIN, PASS, FAIL} state_t;

  state_t             state, state_next;
  logic [HC_W-1:0]    hold_cnt;
  logic [DC_W-1:0]    drain_cnt;
  logic [STALL_W-1:0] stall_cnt;

  logic [N_CH-1:0]    ch_done_next;
  logic [N_CH-1:0]    fail_vec;
  logic               hold_last, drain_last, all_done;
  logic               fault_ch, fault_to, fault_st, fault;
  logic [1:0]         fault_code;
  logic [FC_W-1:0]    fault_idx;

  // Fault detection, completion detection and lowest failing channel index
  always_comb begin
    ch_done_next = ch_done | (ch_success & cfg_ch_mask);
    fail_vec     = ch_failure & cfg_ch_mask;
    hold_last    = (hold_cnt == HC_W'(RESET_CYCLES - 1));
    drain_last   = (drain_cnt == DC_W'(DRAIN_CYCLES - 1));
    all_done     = (ch_done_next == cfg_ch_mask) && (cfg_ch_mask != '0);
    fault_ch     = |fail_vec;
    fault_to     = (cfg_max_cycles != '0) && (cycle_count >= cfg_max_cycles);
    fault_st     = (state == RUN) && (cfg_stall_limit != '0) && (stall_cnt >= cfg_stall_limit);
    fault        = fault_ch || fault_to || fault_st;
    fault_code   = fault_ch ? 2'd1 : fault_to ? 2'd2 : fault_st ? 2'd3 : 2'd0;
    fault_idx    = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (fail_vec[i-1]) fault_idx = FC_W'(i - 1);
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= HOLD;
    else       state <= state_next;
  end

  // Next-state logic; a fault always wins over completion
  always_comb begin
    state_next = state;
    case (state)
      HOLD:    if (hold_last) state_next = RUN;
      RUN: begin
        if (fault)         state_next = FAIL;
        else if (all_done) state_next = DRAIN;
      end
      DRAIN: begin
        if (fault)           state_next = FAIL;
        else if (drain_last) state_next = PASS;
      end
      default: state_next = state;
    endcase
  end

  // Verdict outputs decoded from the registered state
  always_comb begin
    done   = (state == PASS) || (state == FAIL);
    passed = (state == PASS);
  end

  // Counters, sticky channel flags, DUT reset and fail cause; everything freezes on the fault edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dut_reset    <= 1'b1;
      hold_cnt     <= '0;
      drain_cnt    <= '0;
      stall_cnt    <= '0;
      cycle_count  <= '0;
      ch_done      <= '0;
      fail_code    <= '0;
      fail_channel <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_last) dut_reset <= 1'b0;
          else           hold_cnt  <= hold_cnt + 1'b1;
        end
        RUN: begin
          if (fault) begin
            fail_code    <= fault_code;
            fail_channel <= fault_idx;
          end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            ch_done <= ch_done_next;
            if (heartbeat)             stall_cnt <= '0;
            else if (stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
            if (all_done) drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (fault) begin
            fail_code    <= fault_code;
            fail_channel <= fault_idx;
          end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
            ch_done   <= ch_done_next;
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TEST_RUN_TRACE_EN
`ifndef SYNTHESIS
  // Trace every state transition (and the fail cause)
  always_ff @(posedge clock) begin
    if (!reset && (state_next != state)) begin
      $display("[trc] %s->%s @%0d", state.name(), state_next.name(), cycle_count);
      if (state_next == FAIL)
        $display("[trc] fail_code=%0d fail_channel=%0d", fault_code, fault_idx);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_test_run_controller.sv
// Directed bench for test_run_controller with default parameters.
module tb_test_run_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] cfg_max_cycles = '0;
  logic [15:0] cfg_stall_limit = '0;
  logic [3:0]  cfg_ch_mask = '0;
  logic [3:0]  ch_success = '0;
  logic [3:0]  ch_failure = '0;
  logic        heartbeat = 1'b0;
  logic        dut_reset;
  logic [63:0] cycle_count;
  logic [3:0]  ch_done;
  logic        done, passed;
  logic [1:0]  fail_code;
  logic [1:0]  fail_channel;

  int checks = 0;
  int fails  = 0;

  test_run_controller #(
    .N_CH(4), .CNT_W(64), .STALL_W(16), .RESET_CYCLES(16), .DRAIN_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_max_cycles(cfg_max_cycles), .cfg_stall_limit(cfg_stall_limit),
    .cfg_ch_mask(cfg_ch_mask), .ch_success(ch_success), .ch_failure(ch_failure),
    .heartbeat(heartbeat), .dut_reset(dut_reset), .cycle_count(cycle_count),
    .ch_done(ch_done), .done(done), .passed(passed),
    .fail_code(fail_code), .fail_channel(fail_channel)
  );

  always #5 clock = ~clock;

  // Reset, configure, and wait out HOLD; returns on the negedge after the RUN entry edge
  task automatic start_run(input logic [3:0] m, input logic [63:0] mx, input logic [15:0] sl);
    @(negedge clock);
    reset = 1'b1;
    cfg_ch_mask = m; cfg_max_cycles = mx; cfg_stall_limit = sl;
    ch_success = '0; ch_failure = '0; heartbeat = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (16) @(negedge clock);
  endtask

  task automatic test_reset;
    cfg_ch_mask = 4'b1111; cfg_max_cycles = '0; cfg_stall_limit = '0;
    @(negedge clock);
    checks++; if (dut_reset !== 1'b1) begin fails++; $display("FAIL reset_dut_reset: got %0b expected 1", dut_reset); end
    checks++; if ({done, passed, fail_code, fail_channel} !== 6'b0) begin fails++; $display("FAIL reset_verdict: got %b expected 000000", {done, passed, fail_code, fail_channel}); end
    checks++; if (cycle_count !== 64'd0) begin fails++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
    checks++; if (ch_done !== 4'b0) begin fails++; $display("FAIL reset_ch_done: got %b expected 0000", ch_done); end
    // Inputs active during HOLD must be ignored
    ch_success = 4'b1111; ch_failure = 4'b1111; heartbeat = 1'b1;
    reset = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      checks++;
      if (dut_reset !== 1'b1 || done !== 1'b0 || ch_done !== 4'b0 || cycle_count !== 64'd0) begin
        fails++;
        $display("FAIL hold_edge%0d: got dut_reset=%0b done=%0b ch_done=%b cc=%0d expected 1 0 0000 0", i, dut_reset, done, ch_done, cycle_count);
      end
    end
    ch_success = '0; ch_failure = '0; heartbeat = 1'b0;
    @(negedge clock);
    checks++; if (dut_reset !== 1'b0) begin fails++; $display("FAIL hold_release: got dut_reset=%0b expected 0", dut_reset); end
    checks++; if (ch_done !== 4'b0 || done !== 1'b0) begin fails++; $display("FAIL hold_ignored: got ch_done=%b done=%0b expected 0000 0", ch_done, done); end
    @(negedge clock);
    checks++; if (cycle_count !== 64'd1) begin fails++; $display("FAIL run_first_count: got %0d expected 1", cycle_count); end
  endtask

  task automatic test_pass;
    start_run(4'b1011, 64'd0, 16'd0);
    ch_success = 4'b0001; @(negedge clock); ch_success = '0;
    checks++; if (ch_done !== 4'b0001 || cycle_count !== 64'd1) begin fails++; $display("FAIL pass_ch0: got ch_done=%b cc=%0d expected 0001 1", ch_done, cycle_count); end
    @(negedge clock);
    ch_success = 4'b1000; @(negedge clock);
    ch_success = 4'b0100; // unmasked
    checks++; if (ch_done !== 4'b1001) begin fails++; $display("FAIL pass_ch3: got %b expected 1001", ch_done); end
    @(negedge clock);
    checks++; if (ch_done !== 4'b1001) begin fails++; $display("FAIL pass_unmasked: got %b expected 1001", ch_done); end
    ch_success = 4'b0010; // held as a level through drain
    @(negedge clock);
    checks++; if (ch_done !== 4'b1011 || done !== 1'b0 || cycle_count !== 64'd5) begin fails++; $display("FAIL pass_all_done: got ch_done=%b done=%0b cc=%0d expected 1011 0 5", ch_done, done, cycle_count); end
    for (int i = 1; i <= 7; i++) begin
      @(negedge clock);
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL pass_drain%0d: got done=%0b expected 0", i, done); end
    end
    @(negedge clock);
    checks++; if ({done, passed, fail_code} !== 4'b1100) begin fails++; $display("FAIL pass_verdict: got done=%0b passed=%0b code=%0d expected 1 1 0", done, passed, fail_code); end
    checks++; if (cycle_count !== 64'd13) begin fails++; $display("FAIL pass_cycle_count: got %0d expected 13", cycle_count); end
    ch_failure = 4'b1111;
    repeat (3) @(negedge clock);
    checks++; if ({done, passed, fail_code} !== 4'b1100 || cycle_count !== 64'd13) begin fails++; $display("FAIL pass_held: got done=%0b passed=%0b code=%0d cc=%0d expected 1 1 0 13", done, passed, fail_code, cycle_count); end
    ch_success = '0; ch_failure = '0;
  endtask

  task automatic test_channel_priority;
    logic [3:0]  tm [4] = '{4'b1111, 4'b1011, 4'b1001, 4'b1100};
    logic [63:0] tx [4] = '{64'd5, 64'd5, 64'd5, 64'd0};
    logic [1:0]  tc [4] = '{2'd1, 2'd1, 2'd2, 2'd1};
    logic [1:0]  tf [4] = '{2'd1, 2'd1, 2'd0, 2'd2};
    for (int k = 0; k < 4; k++) begin
      start_run(tm[k], tx[k], 16'd0);
      repeat (5) @(negedge clock);
      checks++; if (cycle_count !== 64'd5 || done !== 1'b0) begin fails++; $display("FAIL prio%0d_pre: got cc=%0d done=%0b expected 5 0", k, cycle_count, done); end
      ch_failure = 4'b0110;
      @(negedge clock);
      ch_failure = '0;
      checks++;
      if (done !== 1'b1 || passed !== 1'b0 || fail_code !== tc[k] || fail_channel !== tf[k]) begin
        fails++;
        $display("FAIL prio%0d: got done=%0b passed=%0b code=%0d chan=%0d expected 1 0 %0d %0d", k, done, passed, fail_code, fail_channel, tc[k], tf[k]);
      end
      checks++; if (cycle_count !== 64'd5) begin fails++; $display("FAIL prio%0d_frozen: got cc=%0d expected 5", k, cycle_count); end
    end
  endtask

  task automatic test_timeout;
    start_run(4'b0000, 64'd100, 16'd0);
    ch_success = 4'b1111; // mask 0: pass impossible
    repeat (100) @(negedge clock);
    checks++; if (cycle_count !== 64'd100 || done !== 1'b0 || ch_done !== 4'b0) begin fails++; $display("FAIL timeout_pre: got cc=%0d done=%0b ch_done=%b expected 100 0 0000", cycle_count, done, ch_done); end
    @(negedge clock);
    checks++; if (done !== 1'b1 || passed !== 1'b0 || fail_code !== 2'd2) begin fails++; $display("FAIL timeout: got done=%0b passed=%0b code=%0d expected 1 0 2", done, passed, fail_code); end
    checks++; if (cycle_count !== 64'd100) begin fails++; $display("FAIL timeout_frozen: got cc=%0d expected 100", cycle_count); end
    ch_success = '0;
  endtask

  task automatic test_stall;
    start_run(4'b1111, 64'd0, 16'd10);
    for (int p = 0; p < 4; p++) begin
      heartbeat = 1'b1; @(negedge clock); heartbeat = 1'b0;
      if (p < 3) repeat (4) @(negedge clock);
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL stall_quiet%0d: got done=%0b expected 0", k, done); end
    end
    @(negedge clock);
    checks++; if (done !== 1'b1 || passed !== 1'b0 || fail_code !== 2'd3) begin fails++; $display("FAIL stall: got done=%0b passed=%0b code=%0d expected 1 0 3", done, passed, fail_code); end
    checks++; if (cycle_count !== 64'd26) begin fails++; $display("FAIL stall_count: got cc=%0d expected 26", cycle_count); end
  endtask

  task automatic test_stall_in_drain;
    start_run(4'b0001, 64'd0, 16'd10);
    heartbeat = 1'b1; @(negedge clock); heartbeat = 1'b0;
    repeat (4) @(negedge clock);
    heartbeat = 1'b1; @(negedge clock); heartbeat = 1'b0;
    repeat (9) @(negedge clock);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL drain_stall_pre: got done=%0b expected 0", done); end
    ch_success = 4'b0001; @(negedge clock); ch_success = '0;
    checks++; if (done !== 1'b0 || ch_done !== 4'b0001) begin fails++; $display("FAIL drain_stall_entry: got done=%0b ch_done=%b expected 0 0001", done, ch_done); end
    repeat (7) @(negedge clock);
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL drain_stall_mid: got done=%0b expected 0", done); end
    @(negedge clock);
    checks++; if ({done, passed, fail_code} !== 4'b1100 || cycle_count !== 64'd24) begin fails++; $display("FAIL drain_stall_pass: got done=%0b passed=%0b code=%0d cc=%0d expected 1 1 0 24", done, passed, fail_code, cycle_count); end
  endtask

  task automatic test_simultaneous;
    start_run(4'b0111, 64'd0, 16'd0);
    ch_success = 4'b0001; @(negedge clock);
    ch_success = 4'b0010; @(negedge clock);
    ch_success = 4'b0100; ch_failure = 4'b0100; @(negedge clock);
    ch_success = '0; ch_failure = '0;
    checks++; if (done !== 1'b1 || passed !== 1'b0 || fail_code !== 2'd1 || fail_channel !== 2'd2) begin fails++; $display("FAIL simultaneous: got done=%0b passed=%0b code=%0d chan=%0d expected 1 0 1 2", done, passed, fail_code, fail_channel); end
    repeat (2) @(negedge clock);
    checks++; if (done !== 1'b1 || passed !== 1'b0 || fail_code !== 2'd1) begin fails++; $display("FAIL simultaneous_held: got done=%0b passed=%0b code=%0d expected 1 0 1", done, passed, fail_code); end
  endtask

  task automatic test_mid_reset;
    start_run(4'b0001, 64'd0, 16'd0);
    ch_success = 4'b0001; @(negedge clock); ch_success = '0;
    repeat (3) @(negedge clock);
    checks++; if (done !== 1'b0 || ch_done !== 4'b0001 || dut_reset !== 1'b0) begin fails++; $display("FAIL midreset_pre: got done=%0b ch_done=%b dut_reset=%0b expected 0 0001 0", done, ch_done, dut_reset); end
    #2 reset = 1'b1;
    #1;
    checks++; if (dut_reset !== 1'b1 || ch_done !== 4'b0 || cycle_count !== 64'd0) begin fails++; $display("FAIL midreset_async: got dut_reset=%0b ch_done=%b cc=%0d expected 1 0000 0", dut_reset, ch_done, cycle_count); end
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    checks++; if (dut_reset !== 1'b1) begin fails++; $display("FAIL midreset_hold: got dut_reset=%0b expected 1", dut_reset); end
    @(negedge clock);
    checks++; if (dut_reset !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL midreset_release: got dut_reset=%0b done=%0b expected 0 0", dut_reset, done); end
  endtask

  initial begin
    test_reset;
    test_pass;
    test_channel_priority;
    test_timeout;
    test_stall;
    test_stall_in_drain;
    test_simultaneous;
    test_mid_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
